alu_arbiter: RTL and testbench

- Shares the single `alu` instance between two requesters, e.g. the execute stage and the address-generation/branch unit.
- Uses valid/ready handshakes with round-robin arbitration.
- Registers the operands and the result, and holds the response until the consumer accepts it.
- Sits between the decode/issue logic and the existing `alu` combinational datapath, which it instantiates.

---
 rtl/alu_pkg.sv | 9 +
 rtl/alu.sv | 20 ++
 rtl/rr_arb2.sv | 9 +
 rtl/alu_arbiter.sv | 112 +++++++++++
 tb/tb_alu_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU and its two-requester arbiter
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
package alu_pkg;
  typedef enum logic {ALU_ADD = 1'b0, ALU_SUB = 1'b1} alu_mode_e;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_e;
  localparam int NUM_REQ = 2;
endpackage

// File: rtl/alu.sv
// alu: combinational signed add/sub datapath with two's complement overflow flag
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
module alu
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = `WORD_SIZE
) (
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  input  alu_mode_e            mode,
  output logic [WORD_SIZE-1:0] c,
  output logic                 overflow
);
  assign c = (mode == ALU_SUB) ? a - b : a + b;
  assign overflow = ((mode == ALU_SUB) ? (a[WORD_SIZE-1] != b[WORD_SIZE-1])
                                       : (a[WORD_SIZE-1] == b[WORD_SIZE-1]))
                    && (c[WORD_SIZE-1] != a[WORD_SIZE-1]);
endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin grant; on a tie the requester that did not win last time wins
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);
  assign grant[0] = valid[0] && (!valid[1] || last_grant);
  assign grant[1] = valid[1] && (!valid[0] || !last_grant);
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu between two valid/ready requesters; optional ALU_ARB_STATS_EN adds grant counters
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = `WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WORD_SIZE-1:0] req0_a,
  input  logic [WORD_SIZE-1:0] req0_b,
  input  logic                 req0_mode,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WORD_SIZE-1:0] req1_a,
  input  logic [WORD_SIZE-1:0] req1_b,
  input  logic                 req1_mode,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [WORD_SIZE-1:0] rsp_c,
  output logic                 rsp_overflow
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]          grant_cnt0,
  output logic [15:0]          grant_cnt1
`endif
);
  arb_state_e           state, state_nx;
  logic [NUM_REQ-1:0]   arb_grant;
  logic                 last_grant, op_id, fire, alu_ov;
  logic [WORD_SIZE-1:0] op_a, op_b, alu_c;
  alu_mode_e            op_mode;
  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (arb_grant)
  );
  alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
    .a        (op_a),
    .b        (op_b),
    .mode     (op_mode),
    .c        (alu_c),
    .overflow (alu_ov)
  );
  assign req0_ready = rst_n && (state == IDLE) && arb_grant[0];
  assign req1_ready = rst_n && (state == IDLE) && arb_grant[1];
  assign fire = req0_ready || req1_ready;
  // next state: accept in IDLE, one cycle of EXEC, hold RESP until consumed
  always_comb begin
    state_nx = (state == IDLE) ? (fire ? EXEC : IDLE) :
               (state == EXEC) ? RESP :
               (rsp_ready ? IDLE : RESP);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // latch the granted requester's operation and remember who won
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      op_mode    <= ALU_ADD;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
    end else if (fire) begin
      op_a       <= req1_ready ? req1_a : req0_a;
      op_b       <= req1_ready ? req1_b : req0_b;
      op_mode    <= alu_mode_e'(req1_ready ? req1_mode : req0_mode);
      op_id      <= req1_ready;
      last_grant <= req1_ready;
    end
  end
  // capture the alu result after EXEC and hold it until the consumer accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_c        <= '0;
      rsp_overflow <= 1'b0;
    end else if (state == EXEC) begin
      rsp_valid    <= 1'b1;
      rsp_id       <= op_id;
      rsp_c        <= alu_c;
      rsp_overflow <= alu_ov;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid    <= 1'b0;
    end
  end
`ifdef ALU_ARB_STATS_EN
  // saturating per-requester count of accepted handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req1_ready && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif
  a_req0_hold: assert property (@(posedge clk) disable iff (!rst_n)
    req0_valid && !req0_ready |=> req0_valid && $stable(req0_a) && $stable(req0_b) && $stable(req0_mode));
  a_req1_hold: assert property (@(posedge clk) disable iff (!rst_n)
    req1_valid && !req1_ready |=> req1_valid && $stable(req1_a) && $stable(req1_b) && $stable(req1_mode));
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter; define ALU_ARB_STATS_EN to also cover the grant counters
module tb_alu_arbiter;
  localparam int W = 16;
  typedef struct {
    logic         id;
    logic [W-1:0] c;
    logic         ov;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, req0_mode = 1'b0, req1_mode = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_overflow;
  logic rsp_ready = 1'b1;
  logic [W-1:0] rsp_c;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_pass = 0;
  alu_arbiter #(.WORD_SIZE(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_mode    (req0_mode),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_mode    (req1_mode),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_c        (rsp_c),
    .rsp_overflow (rsp_overflow)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    int sa, sb, full;
    exp_t r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    full = m ? sa - sb : sa + sb;
    r.id = id;
    r.c = full[W-1:0];
    r.ov = (full > (2 ** (W - 1)) - 1) || (full < -(2 ** (W - 1)));
    return r;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic m, input bit push);
    int n = 0;
    bit ok = 0;
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_mode = m; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_mode = m; end
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = id ? req1_ready : req0_ready;
      n++;
    end
    chk(id ? "handshake1" : "handshake0", 32'(ok), 32'd1);
    if (ok && push) q.push_back(model(id, a, b, m));
    step();
    if (id) req1_valid = 0;
    else req0_valid = 0;
  endtask
  task automatic do_reset();
    rst_n = 0;
    repeat (2) step();
    rst_n = 1;
  endtask
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) chk("sb_unexpected", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_c", 32'(rsp_c), 32'(e.c));
        chk("rsp_ov", 32'(rsp_overflow), 32'(e.ov));
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    req0_valid = 1;
    req1_valid = 1;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_c", 32'(rsp_c), 32'd0);
    chk("rst_rsp_ov", 32'(rsp_overflow), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    req0_valid = 0;
    req1_valid = 0;
    repeat (2) step();
    rst_n = 1;
    send(0, 16'd2, 16'd3, 1'b0, 1);
    @(negedge clk);
    chk("t1_exec_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("t1_resp_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    chk("t1_idle_valid", 32'(rsp_valid), 32'd0);
    step();
    do_reset();
    fork
      send(0, 16'd5, -16'sd1, 1'b1, 1);
      send(1, 16'd127, 16'd1, 1'b0, 1);
      begin
        @(negedge clk);
        chk("t2_ready0", 32'(req0_ready), 32'd1);
        chk("t2_ready1", 32'(req1_ready), 32'd0);
      end
    join
    repeat (3) step();
    send(1, 16'd32767, 16'd1, 1'b0, 1);
    send(1, 16'h8000, 16'd1, 1'b1, 1);
    send(0, -16'sd5, 16'd3, 1'b0, 1);
    repeat (3) step();
    rsp_ready = 0;
    fork
      send(0, 16'd10, 16'd4, 1'b1, 1);
      send(1, 16'd100, -16'sd50, 1'b0, 1);
      begin
        int n = 0;
        logic [W-1:0] c0;
        logic id0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk("t4_rsp_seen", 32'(rsp_valid), 32'd1);
        c0 = rsp_c;
        id0 = rsp_id;
        chk("t4_first_id", 32'(id0), 32'd1);
        chk("t4_first_c", 32'(c0), 32'd50);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
          chk("t4_hold_c", 32'(rsp_c), 32'(c0));
          chk("t4_hold_id", 32'(rsp_id), 32'(id0));
          chk("t4_ready0", 32'(req0_ready), 32'd0);
          chk("t4_ready1", 32'(req1_ready), 32'd0);
        end
        step();
        rsp_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("t4_next_grant0", 32'(req0_ready), 32'd1);
      end
    join
    repeat (3) step();
    send(0, 16'd1, 16'd1, 1'b0, 0);
    rst_n = 0;
    #1;
    chk("t5_rst_valid", 32'(rsp_valid), 32'd0);
    step();
    @(negedge clk);
    chk("t5_rst_hold", 32'(rsp_valid), 32'd0);
    step();
    rst_n = 1;
    fork
      send(0, 16'd7, 16'd8, 1'b0, 1);
      send(1, 16'd3, 16'd9, 1'b1, 1);
      begin
        @(negedge clk);
        chk("t5_ready0", 32'(req0_ready), 32'd1);
        chk("t5_ready1", 32'(req1_ready), 32'd0);
      end
    join
    repeat (4) step();
`ifdef ALU_ARB_STATS_EN
    do_reset();
    send(0, 16'd1, 16'd2, 1'b0, 1);
    send(1, 16'd3, 16'd4, 1'b0, 1);
    send(0, 16'd5, 16'd6, 1'b1, 1);
    send(1, 16'd7, 16'd8, 1'b1, 1);
    send(1, 16'd9, 16'd1, 1'b0, 1);
    repeat (3) step();
    chk("t6_cnt0", 32'(grant_cnt0), 32'd2);
    chk("t6_cnt1", 32'(grant_cnt1), 32'd3);
    force dut.grant_cnt0 = 16'hFFFF;
    step();
    release dut.grant_cnt0;
    send(0, 16'd1, 16'd1, 1'b0, 1);
    repeat (3) step();
    chk("t6_cnt0_sat", 32'(grant_cnt0), 32'hFFFF);
`endif
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
